seqdet_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one serial Moore pattern detector between two parallel-word requesters.
//  - Accepts a W-bit word from the granted channel.
//  - Clears the detector, then serializes the word MSB-first onto det_din.
//  - Counts det_hit pulses, including the one caused by the final bit.
//  - Returns a per-word hit count on a valid/ready result port.

---
 rtl/seqdet_rr_sched.sv | 121 ++++++++++++
 tb/tb_seqdet_rr_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_rr_sched.sv
// Round-robin front end that shares one serial Moore pattern detector
// between two word requesters and reports the hit count per word.
module seqdet_rr_sched #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic             det_din,
    output logic             det_clr,
    input  logic             det_hit,
    output logic             res_valid,
    output logic             res_ch,
    output logic [CNT_W-1:0] res_count,
    input  logic             res_ready,
    output logic             busy
);

    localparam int BW = $clog2(W);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        FLUSH,
        REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] hitcnt_q, hitcnt_d;
    logic             cur_ch_q, cur_ch_d;
    logic             last_ch_q, last_ch_d;

    logic gnt;
    logic idle;
    logic accept;

    // Both valid: the channel not served last wins; otherwise the valid one.
    assign gnt        = (req0_valid & req1_valid) ? ~last_ch_q : req1_valid;
    assign idle       = (state_q == IDLE);
    assign req0_ready = idle & ~clr & req0_valid & ~gnt;
    assign req1_ready = idle & ~clr & req1_valid & gnt;
    assign accept     = req0_ready | req1_ready;

    assign det_clr   = clr | (state_q == CLEAR);
    assign det_din   = (state_q == SHIFT) & shreg_q[W-1];
    assign res_valid = (state_q == REPORT);
    assign res_ch    = cur_ch_q;
    assign res_count = hitcnt_q;
    assign busy      = ~idle;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            hitcnt_q  <= '0;
            cur_ch_q  <= 1'b0;
            last_ch_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            hitcnt_q  <= hitcnt_d;
            cur_ch_q  <= cur_ch_d;
            last_ch_q <= last_ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        hitcnt_d  = hitcnt_q;
        cur_ch_d  = cur_ch_q;
        last_ch_d = last_ch_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = gnt ? req1_data : req0_data;
                    cur_ch_d = gnt;
                    bitcnt_d = '0;
                    hitcnt_d = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: state_d = SHIFT;
            SHIFT: begin
                // A hit seen in the first SHIFT cycle predates this word.
                if (det_hit && bitcnt_q != '0 && hitcnt_q != CMAX)
                    hitcnt_d = hitcnt_q + 1'b1;
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BW'(W - 1))
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (det_hit && hitcnt_q != CMAX)
                    hitcnt_d = hitcnt_q + 1'b1;
                state_d = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    last_ch_d = cur_ch_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Bench for seqdet_rr_sched: a behavioural 1101 detector feeds the DUT and
// results are compared against table constants and a window-count model.
module tb_seqdet_rr_sched;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = '0;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = '0;
    logic       res_ready = 1'b0;

    logic       req0_ready, req1_ready, det_din, det_clr, det_hit;
    logic       res_valid, res_ch, busy;
    logic [3:0] res_count;

    logic       s_r0, s_r1, s_din, s_clr, s_hit, s_valid, s_ch, s_busy;
    logic [0:0] s_count;

    logic [3:0] h0 = '0;
    logic [3:0] h1 = '0;
    logic       hit0 = 1'b0;
    logic       hit1 = 1'b0;

    int checks   = 0;
    int failures = 0;
    logic mlast;

    assign det_hit = hit0;
    assign s_hit   = hit1;

    always #5 clk = ~clk;

    seqdet_rr_sched #(.W(W), .CNT_W(4)) u_dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .det_din(det_din), .det_clr(det_clr), .det_hit(det_hit),
        .res_valid(res_valid), .res_ch(res_ch), .res_count(res_count),
        .res_ready(res_ready), .busy(busy)
    );

    seqdet_rr_sched #(.W(W), .CNT_W(1)) u_sat (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
        .det_din(s_din), .det_clr(s_clr), .det_hit(s_hit),
        .res_valid(s_valid), .res_ch(s_ch), .res_count(s_count),
        .res_ready(res_ready), .busy(s_busy)
    );

    // Moore overlapping-1101 detectors, one per DUT.
    always @(posedge clk) begin
        if (det_clr) begin
            h0   <= '0;
            hit0 <= 1'b0;
        end else begin
            h0   <= {h0[2:0], det_din};
            hit0 <= ({h0[2:0], det_din} == 4'b1101);
        end
    end

    always @(posedge clk) begin
        if (s_clr) begin
            h1   <= '0;
            hit1 <= 1'b0;
        end else begin
            h1   <= {h1[2:0], s_din};
            hit1 <= ({h1[2:0], s_din} == 4'b1101);
        end
    end

    function automatic int count_hits(input logic [7:0] w);
        int n = 0;
        for (int i = 7; i >= 3; i--)
            if ({w[i], w[i-1], w[i-2], w[i-3]} == 4'b1101) n++;
        return n;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Called just after a falling edge with the DUT idle; returns likewise.
    task automatic transact(input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1,
                            input logic ech, input int ecnt,
                            input int esat, input int hold);
        int  lat;
        bit  done;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        res_ready  = 1'b0;
        #1;
        chk("ready0", int'(req0_ready), int'(v0 && !ech));
        chk("ready1", int'(req1_ready), int'(v1 && ech));
        @(posedge clk);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            if (res_valid) begin
                done = 1'b1;
            end else begin
                chk("busy_ready", int'(req0_ready | req1_ready), 0);
                @(posedge clk);
                lat++;
            end
        end
        chk("res_timeout", int'(done), 1);
        chk("latency", lat, W + 2);
        chk("res_ch", int'(res_ch), int'(ech));
        chk("res_count", int'(res_count), ecnt);
        chk("sat_valid", int'(s_valid), 1);
        chk("sat_count", int'(s_count), esat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_ch", int'(res_ch), int'(ech));
            chk("hold_count", int'(res_count), ecnt);
            chk("hold_ready", int'(req0_ready | req1_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("post_valid", int'(res_valid), 0);
        chk("post_busy", int'(busy), 0);
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ech;
        int         ecnt;
        int         esat;
        int         hold;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 8'b1101_1010, 1'b0, 8'h00, 1'b0, 2, 1, 0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 8'b1101_1101, 1'b1, 2, 1, 5};
        tbl[2] = '{1'b1, 8'hFF, 1'b1, 8'h6D, 1'b0, 0, 0, 1};
        tbl[3] = '{1'b1, 8'h00, 1'b1, 8'h6D, 1'b1, 2, 1, 0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 0, 0, 2};
        tbl[5] = '{1'b1, 8'hD0, 1'b1, 8'hFF, 1'b0, 1, 1, 0};

        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_ch", int'(res_ch), 0);
        chk("rst_count", int'(res_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_din", int'(det_din), 0);
        chk("rst_detclr", int'(det_clr), 1);
        chk("rst_ready", int'(req0_ready), 0);
        req0_valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        mlast = 1'b1;

        for (int i = 0; i < 6; i++) begin
            transact(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1,
                     tbl[i].ech, tbl[i].ecnt, tbl[i].esat, tbl[i].hold);
            mlast = tbl[i].ech;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Abort mid-SHIFT: no result, detector held clear, grant back to 0.
        @(negedge clk);
        req1_valid = 1'b1;
        req1_data  = 8'hDD;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_busy", int'(busy), 1);
        clr = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(res_valid), 0);
        chk("abort_detclr", int'(det_clr), 1);
        chk("abort_din", int'(det_din), 0);
        chk("abort_ready", int'(req0_ready), 0);
        @(negedge clk);
        clr = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk("abort_detclr_off", int'(det_clr), 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_res", int'(res_valid | busy), 0);
        end
        mlast = 1'b1;

        // Both channels valid back to back: grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a, b, w;
            logic       e;
            a = 8'($urandom);
            b = 8'($urandom);
            e = ~mlast;
            w = e ? b : a;
            transact(1'b1, a, 1'b1, b, e, count_hits(w),
                     sat(count_hits(w), 1), 0);
            chk("fair_order", int'(e), i % 2);
            mlast = e;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        for (int i = 0; i < 24; i++) begin
            logic [7:0] a, b, w;
            logic       v0, v1, e;
            int         mode, n;
            mode = int'($urandom_range(0, 2));
            a    = 8'($urandom);
            b    = 8'($urandom);
            if (i % 3 == 0) a = {4'b1101, a[3:0]};
            v0 = (mode != 1);
            v1 = (mode != 0);
            e  = (mode == 2) ? ~mlast : v1;
            w  = e ? b : a;
            n  = count_hits(w);
            transact(v0, a, v1, b, e, sat(n, 15), sat(n, 1),
                     int'($urandom_range(0, 2)));
            mlast = e;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
